// File: rtl/cond_unit_e.sv
// Execute-stage condition unit: registers Decode controls, evaluates the
// condition against the flag register, gates side effects, counts squashes.
// Ports: clk, reset (async, active-high); StallE/FlushE pipeline controls;
//   CondD, FlagWriteD, RegWriteD, MemWriteD, PCSrcD, BranchD from Decode;
//   ALUFlags {N,Z,C,V} from the ALU; gated RegWriteE, MemWriteE, PCSrcE,
//   BranchTakenE, CondExE; architectural Flags; saturating SquashCount.
module cond_unit_e (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [3:0]  CondD,
  input  logic [1:0]  FlagWriteD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        PCSrcD,
  input  logic        BranchD,
  input  logic [3:0]  ALUFlags,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        PCSrcE,
  output logic        BranchTakenE,
  output logic        CondExE,
  output logic [3:0]  Flags,
  output logic [15:0] SquashCount
);

  logic [3:0]  cond_q, cond_d;
  logic [1:0]  fw_q, fw_d;
  logic        rw_q, rw_d;
  logic        mw_q, mw_d;
  logic        pcs_q, pcs_d;
  logic        br_q, br_d;
  logic        valid_q, valid_d;
  logic [3:0]  flags_q, flags_d;
  logic [15:0] sq_q, sq_d;

  logic n, z, c, v;
  logic cond_ok;

  assign {n, z, c, v} = flags_q;

  // Evaluated on the pre-update flags; no bypass of ALUFlags.
  always_comb begin
    cond_ok = 1'b0;
    unique case (cond_q)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = !z && c;
      4'b1001: cond_ok = z || !c;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = !z && (n == v);
      4'b1101: cond_ok = z || (n != v);
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = 1'b0;
    endcase
  end

  assign CondExE      = cond_ok & valid_q;
  assign RegWriteE    = rw_q & CondExE;
  assign MemWriteE    = mw_q & CondExE;
  assign PCSrcE       = pcs_q & CondExE;
  assign BranchTakenE = br_q & CondExE;
  assign Flags        = flags_q;
  assign SquashCount  = sq_q;

  always_comb begin
    cond_d  = cond_q;
    fw_d    = fw_q;
    rw_d    = rw_q;
    mw_d    = mw_q;
    pcs_d   = pcs_q;
    br_d    = br_q;
    valid_d = valid_q;
    flags_d = flags_q;
    sq_d    = sq_q;

    // Flush wins over stall and loads a never-true bubble.
    if (FlushE) begin
      cond_d  = 4'b1111;
      fw_d    = 2'b00;
      rw_d    = 1'b0;
      mw_d    = 1'b0;
      pcs_d   = 1'b0;
      br_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!StallE) begin
      cond_d  = CondD;
      fw_d    = FlagWriteD;
      rw_d    = RegWriteD;
      mw_d    = MemWriteD;
      pcs_d   = PCSrcD;
      br_d    = BranchD;
      valid_d = 1'b1;
    end

    // Retirement effects happen only on the edge that moves the
    // instruction out, so a stalled one is counted once.
    if (!StallE) begin
      if (CondExE) begin
        if (fw_q[1]) flags_d[3:2] = ALUFlags[3:2];
        if (fw_q[0]) flags_d[1:0] = ALUFlags[1:0];
      end
      if (valid_q && !cond_ok && (sq_q != 16'hFFFF))
        sq_d = sq_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q  <= 4'b1111;
      fw_q    <= 2'b00;
      rw_q    <= 1'b0;
      mw_q    <= 1'b0;
      pcs_q   <= 1'b0;
      br_q    <= 1'b0;
      valid_q <= 1'b0;
      flags_q <= 4'b0000;
      sq_q    <= 16'h0000;
    end else begin
      cond_q  <= cond_d;
      fw_q    <= fw_d;
      rw_q    <= rw_d;
      mw_q    <= mw_d;
      pcs_q   <= pcs_d;
      br_q    <= br_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      sq_q    <= sq_d;
    end
  end

endmodule

// File: tb/tb_cond_unit_e.sv
// Directed bench for cond_unit_e.
// Drives Decode vectors, checks gated outputs, Flags and SquashCount.
module tb_cond_unit_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallE, FlushE;
  logic [3:0]  CondD;
  logic [1:0]  FlagWriteD;
  logic        RegWriteD, MemWriteD, PCSrcD, BranchD;
  logic [3:0]  ALUFlags;
  logic        RegWriteE, MemWriteE, PCSrcE, BranchTakenE, CondExE;
  logic [3:0]  Flags;
  logic [15:0] SquashCount;

  int nvec = 0;
  int nfail = 0;

  cond_unit_e dut (
    .clk(clk), .reset(reset),
    .StallE(StallE), .FlushE(FlushE),
    .CondD(CondD), .FlagWriteD(FlagWriteD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .PCSrcD(PCSrcD), .BranchD(BranchD),
    .ALUFlags(ALUFlags),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
    .CondExE(CondExE), .Flags(Flags),
    .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    nvec++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [3:0] c, input logic [1:0] fw,
                      input logic rw, input logic mw,
                      input logic pcs, input logic br);
    CondD = c; FlagWriteD = fw;
    RegWriteD = rw; MemWriteD = mw;
    PCSrcD = pcs; BranchD = br;
  endtask

  initial begin
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    ALUFlags = 4'b0000;
    setd(4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_condex", {15'd0, CondExE}, 16'd0);
    chk("rst_rw", {15'd0, RegWriteE}, 16'd0);
    chk("rst_flags", {12'd0, Flags}, 16'd0);
    chk("rst_sq", SquashCount, 16'd0);
    reset = 1'b0;

    // EQ with Z=0 fails
    setd(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("eq_fail_cx", {15'd0, CondExE}, 16'd0);
    chk("eq_fail_rw", {15'd0, RegWriteE}, 16'd0);
    // AL writing all flags
    setd(4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    ALUFlags = 4'b0100;
    step();
    chk("sq_one", SquashCount, 16'd1);
    chk("al_cx", {15'd0, CondExE}, 16'd1);
    chk("flags_pre", {12'd0, Flags}, 16'd0);
    setd(4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    ALUFlags = 4'b0000;
    chk("flags_z", {12'd0, Flags}, 16'h0004);
    chk("eq_pass_cx", {15'd0, CondExE}, 16'd1);
    chk("eq_pass_rw", {15'd0, RegWriteE}, 16'd1);

    // Set N=1,V=0 then LT / GE branches
    setd(4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    ALUFlags = 4'b1000;
    setd(4'b1011, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("flags_n", {12'd0, Flags}, 16'h0008);
    chk("lt_bt", {15'd0, BranchTakenE}, 16'd1);
    chk("lt_pcs", {15'd0, PCSrcE}, 16'd1);
    setd(4'b1010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("ge_bt", {15'd0, BranchTakenE}, 16'd0);
    chk("ge_pcs", {15'd0, PCSrcE}, 16'd0);

    // Failing EQ with flag writes must not touch Flags
    setd(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    ALUFlags = 4'b1111;
    chk("eq2_cx", {15'd0, CondExE}, 16'd0);
    setd(4'b1110, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("nofw_flags", {12'd0, Flags}, 16'h0008);
    chk("sq_three", SquashCount, 16'd3);
    chk("al_outs",
        {12'd0, RegWriteE, MemWriteE, PCSrcE, BranchTakenE}, 16'h000F);

    // Flush beats stall
    FlushE = 1'b1; StallE = 1'b1;
    step();
    chk("flush_outs",
        {11'd0, CondExE, RegWriteE, MemWriteE, PCSrcE, BranchTakenE},
        16'd0);
    chk("flush_sq", SquashCount, 16'd3);
    FlushE = 1'b0; StallE = 1'b0;

    // Failing EQ stalled three edges counts once
    setd(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("bubble_nocount", SquashCount, 16'd3);
    StallE = 1'b1;
    repeat (3) step();
    chk("stall_sq", SquashCount, 16'd3);
    chk("stall_cx", {15'd0, CondExE}, 16'd0);
    StallE = 1'b0;
    setd(4'b1110, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("stall_once", SquashCount, 16'd4);
    chk("after_stall_rw", {15'd0, RegWriteE}, 16'd1);

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("arst_rw", {15'd0, RegWriteE}, 16'd0);
    chk("arst_cx", {15'd0, CondExE}, 16'd0);
    chk("arst_flags", {12'd0, Flags}, 16'd0);
    chk("arst_sq", SquashCount, 16'd0);
    reset = 1'b0;
    setd(4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("post_rst_ne", {15'd0, CondExE}, 16'd1);

    // Saturation: one squash per edge
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    setd(4'b1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("sat_start", SquashCount, 16'd0);
    repeat (65534) step();
    chk("sat_fffe", SquashCount, 16'hFFFE);
    step();
    chk("sat_ffff", SquashCount, 16'hFFFF);
    step();
    chk("sat_hold", SquashCount, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
